fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/core_pkg.sv | 27 ++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: PC source select and the fetch-stage FSM encoding.
package core_pkg;

   // PC source select driven by the execute stage.
   typedef enum logic [1:0] {
      PC_PLUS4   = 2'd0,
      ALU_RESULT = 2'd1,
      PC_TRAP    = 2'd2,
      PC_MRET    = 2'd3
   } pc_mux;

   // Fetch-stage sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Force an address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request at a time, IF/ID register
// with decode-stall hold, and redirect handling that kills in-flight fetches.
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        instr_req_op,
   output logic [31:0] instr_addr_op,
   input  logic        instr_gnt_ip,
   input  logic        instr_rvalid_ip,
   input  logic [31:0] instr_rdata_ip,
   input  logic        stall_ip,
   input  pc_mux       pc_mux_ip,
   input  logic [31:0] pc_target_ip,
   output logic [31:0] pc_op,
   output logic [31:0] pc4_op,
   output logic        instr_data_valid_op,
   output logic [31:0] instr_data_op
);

   fetch_state_e state_q, state_n;
   logic [31:0]  pc_q, pc_n;
   logic [31:0]  req_addr_q;
   logic         kill_q, kill_n;
   logic         redirect;
   logic         ld_fetch, ld_hold, ld_from_hold;

   logic [31:0]  hold_instr_q, hold_pc_q;
   logic         if_valid_q;
   logic [31:0]  if_instr_q, if_pc_q, if_pc4_q;

   assign redirect = (pc_mux_ip == ALU_RESULT);

   // Next-state, next-PC and load strobes; a redirect always wins the PC.
   always_comb begin
      state_n      = state_q;
      pc_n         = pc_q;
      kill_n       = kill_q;
      ld_fetch     = 1'b0;
      ld_hold      = 1'b0;
      ld_from_hold = 1'b0;
      case (state_q)
         IDLE: state_n = REQ;
         REQ: begin
            if (instr_gnt_ip) state_n = WAIT;
            if (redirect)     kill_n  = 1'b1;
         end
         WAIT: begin
            if (instr_rvalid_ip) begin
               if (kill_q || redirect) begin
                  state_n = REQ;
                  kill_n  = 1'b0;
               end else if (stall_ip) begin
                  ld_hold = 1'b1;
                  state_n = HOLD;
               end else begin
                  ld_fetch = 1'b1;
                  pc_n     = pc_q + PC_STEP;
                  state_n  = REQ;
               end
            end else if (redirect) begin
               kill_n = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_n = REQ;
            end else if (!stall_ip) begin
               ld_from_hold = 1'b1;
               pc_n         = pc_q + PC_STEP;
               state_n      = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
      if (redirect) pc_n = word_align(pc_target_ip);
   end

   // FSM state, PC, kill flag; the request address is captured on REQ entry
   // so it stays stable while the memory withholds grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= word_align(BOOT_ADDR);
         kill_q     <= 1'b0;
         req_addr_q <= 32'h0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         kill_q  <= kill_n;
         if (state_n == REQ && state_q != REQ) req_addr_q <= pc_n;
      end
   end

   // Hold register parks a response that arrived while decode was stalled.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_instr_q <= 32'h0;
         hold_pc_q    <= 32'h0;
      end else if (ld_hold) begin
         hold_instr_q <= instr_rdata_ip;
         hold_pc_q    <= req_addr_q;
      end
   end

   // IF/ID register: frozen under stall, drops to a bubble once consumed.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_valid_q <= 1'b0;
         if_instr_q <= 32'h0;
         if_pc_q    <= 32'h0;
         if_pc4_q   <= 32'h0;
      end else if (redirect) begin
         if_valid_q <= 1'b0;
      end else if (ld_fetch) begin
         if_valid_q <= 1'b1;
         if_instr_q <= instr_rdata_ip;
         if_pc_q    <= req_addr_q;
         if_pc4_q   <= req_addr_q + PC_STEP;
      end else if (ld_from_hold) begin
         if_valid_q <= 1'b1;
         if_instr_q <= hold_instr_q;
         if_pc_q    <= hold_pc_q;
         if_pc4_q   <= hold_pc_q + PC_STEP;
      end else if (!stall_ip) begin
         if_valid_q <= 1'b0;
      end
   end

   assign instr_req_op        = (state_q == REQ);
   assign instr_addr_op       = req_addr_q;
   assign pc_op               = if_pc_q;
   assign pc4_op              = if_pc4_q;
   assign instr_data_valid_op = if_valid_q;
   assign instr_data_op       = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner cases,
// and a randomized run checked against a decode-side instruction-stream model.
module tb_fetch_stage;
   import core_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        gnt, rvalid, stall;
   logic [31:0] rdata, target;
   pc_mux       mux;

   logic        req, req2, valid, valid2;
   logic [31:0] addr, addr2, pc, pc2, pc4, pc42, instr, instr2;

   int checks   = 0;
   int failures = 0;

   fetch_stage #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clock(clock), .reset(reset),
      .instr_req_op(req), .instr_addr_op(addr),
      .instr_gnt_ip(gnt), .instr_rvalid_ip(rvalid), .instr_rdata_ip(rdata),
      .stall_ip(stall), .pc_mux_ip(mux), .pc_target_ip(target),
      .pc_op(pc), .pc4_op(pc4),
      .instr_data_valid_op(valid), .instr_data_op(instr)
   );

   fetch_stage #(.BOOT_ADDR(32'hFFFF_FFFC)) dut_wrap (
      .clock(clock), .reset(reset),
      .instr_req_op(req2), .instr_addr_op(addr2),
      .instr_gnt_ip(gnt), .instr_rvalid_ip(rvalid), .instr_rdata_ip(rdata),
      .stall_ip(stall), .pc_mux_ip(mux), .pc_target_ip(target),
      .pc_op(pc2), .pc4_op(pc42),
      .instr_data_valid_op(valid2), .instr_data_op(instr2)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory contents: a distinct word per address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_F00D;
   endfunction

   typedef struct packed {
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        st;
      logic        redir;
      logic [31:0] tgt;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] epc4;
      logic [31:0] einstr;
   } vec_t;

   function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                               input logic st, input logic rdr, input logic [31:0] tg,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ep4,
                               input logic [31:0] ei);
      vec_t v;
      v.gnt = g; v.rv = rv; v.rd = rd; v.st = st; v.redir = rdr; v.tgt = tg;
      v.ereq = er; v.eaddr = ea; v.ev = ev; v.epc = ep; v.epc4 = ep4; v.einstr = ei;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic st, input logic rdr, input logic [31:0] tg);
      gnt = g; rvalid = rv; rdata = rd; stall = st;
      mux = rdr ? ALU_RESULT : PC_PLUS4;
      target = tg;
      tick();
   endtask

   task automatic expect_out(input string name, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep,
                             input logic [31:0] ep4, input logic [31:0] ei);
      chk({name, ".req"},   {31'h0, req},   {31'h0, er});
      chk({name, ".addr"},  addr,           ea);
      chk({name, ".valid"}, {31'h0, valid}, {31'h0, ev});
      chk({name, ".pc"},    pc,             ep);
      chk({name, ".pc4"},   pc4,            ep4);
      chk({name, ".instr"}, instr,          ei);
   endtask

   vec_t vt[16];

   // Random-phase model state
   logic [31:0] exp_pc, resp_addr, prev_addr, rtgt;
   logic        outstanding, prev_req, prev_gnt, prev_rv_real, rv_real, rst_stall, rdr;
   int          delay, consumed;

   initial begin
      reset = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; stall = 1'b0;
      mux = PC_PLUS4; target = 32'h0;
      tick();
      tick();
      expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("reset.wrap_req",  {31'h0, req2}, 32'h0);
      chk("reset.wrap_addr", addr2,         32'h0);
      reset = 1'b0;

      // gnt high, rvalid one cycle after grant, stall over the 0x8 response,
      // then a redirect to 0x100 while waiting on 0x10.
      vt[0]  = mk(1,0,0,           0,0,0,      1,32'h0,  0,32'h0,  32'h0,  32'h0);
      vt[1]  = mk(1,0,0,           0,0,0,      0,32'h0,  0,32'h0,  32'h0,  32'h0);
      vt[2]  = mk(1,1,mem(32'h0),  0,0,0,      1,32'h4,  1,32'h0,  32'h4,  mem(32'h0));
      vt[3]  = mk(1,0,0,           0,0,0,      0,32'h4,  0,32'h0,  32'h4,  mem(32'h0));
      vt[4]  = mk(1,1,mem(32'h4),  0,0,0,      1,32'h8,  1,32'h4,  32'h8,  mem(32'h4));
      vt[5]  = mk(1,0,0,           1,0,0,      0,32'h8,  1,32'h4,  32'h8,  mem(32'h4));
      vt[6]  = mk(1,1,mem(32'h8),  1,0,0,      0,32'h8,  1,32'h4,  32'h8,  mem(32'h4));
      vt[7]  = mk(1,0,0,           1,0,0,      0,32'h8,  1,32'h4,  32'h8,  mem(32'h4));
      vt[8]  = mk(1,0,0,           0,0,0,      1,32'hC,  1,32'h8,  32'hC,  mem(32'h8));
      vt[9]  = mk(1,0,0,           0,0,0,      0,32'hC,  0,32'h8,  32'hC,  mem(32'h8));
      vt[10] = mk(1,1,mem(32'hC),  0,0,0,      1,32'h10, 1,32'hC,  32'h10, mem(32'hC));
      vt[11] = mk(1,0,0,           0,0,0,      0,32'h10, 0,32'hC,  32'h10, mem(32'hC));
      vt[12] = mk(0,0,0,           0,1,32'h100,0,32'h10, 0,32'hC,  32'h10, mem(32'hC));
      vt[13] = mk(0,1,mem(32'h10), 0,0,0,      1,32'h100,0,32'hC,  32'h10, mem(32'hC));
      vt[14] = mk(1,0,0,           0,0,0,      0,32'h100,0,32'hC,  32'h10, mem(32'hC));
      vt[15] = mk(1,1,mem(32'h100),0,0,0,      1,32'h104,1,32'h100,32'h104,mem(32'h100));

      for (int i = 0; i < 16; i++) begin
         drive(vt[i].gnt, vt[i].rv, vt[i].rd, vt[i].st, vt[i].redir, vt[i].tgt);
         expect_out($sformatf("vec%0d", i), vt[i].ereq, vt[i].eaddr, vt[i].ev,
                    vt[i].epc, vt[i].epc4, vt[i].einstr);
         if (i == 0) begin
            chk("wrap.first_req",  {31'h0, req2}, 32'h1);
            chk("wrap.first_addr", addr2,         32'hFFFF_FFFC);
         end
         if (i == 2) begin
            chk("wrap.second_addr", addr2,          32'h0);
            chk("wrap.valid",       {31'h0, valid2}, 32'h1);
            chk("wrap.pc",          pc2,            32'hFFFF_FFFC);
            chk("wrap.pc4",         pc42,           32'h0);
            chk("wrap.instr",       instr2,         vt[i].rd);
         end
      end

      // Redirect to 0x203 while grant is withheld for four cycles.
      drive(0,0,0,0,1,32'h203);
      expect_out("gnt_hold0", 1, 32'h104, 0, 32'h100, 32'h104, mem(32'h100));
      for (int i = 1; i < 4; i++) begin
         drive(0,0,0,0,0,0);
         expect_out($sformatf("gnt_hold%0d", i), 1, 32'h104, 0, 32'h100, 32'h104, mem(32'h100));
      end
      drive(1,0,0,0,0,0);
      expect_out("kill_wait", 0, 32'h104, 0, 32'h100, 32'h104, mem(32'h100));
      drive(0,1,mem(32'h104),0,0,0);
      expect_out("kill_drop", 1, 32'h200, 0, 32'h100, 32'h104, mem(32'h100));
      drive(1,0,0,0,0,0);
      drive(0,1,mem(32'h200),0,0,0);
      expect_out("redir_land", 1, 32'h204, 1, 32'h200, 32'h204, mem(32'h200));

      // Reset while waiting on a response; the late response must be ignored.
      drive(1,0,0,0,0,0);
      expect_out("pre_reset_wait", 0, 32'h204, 0, 32'h200, 32'h204, mem(32'h200));
      reset = 1'b1;
      drive(0,0,0,0,0,0);
      expect_out("reset_in_wait", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
      reset = 1'b0;
      drive(0,1,32'hDEAD_BEEF,0,0,0);
      expect_out("late_rv_idle", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
      drive(1,1,32'hDEAD_BEEF,0,0,0);
      expect_out("late_rv_req", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
      drive(0,1,mem(32'h0),0,0,0);
      expect_out("post_reset_fetch", 1, 32'h4, 1, 32'h0, 32'h4, mem(32'h0));

      // Randomized run: decode consumes instructions whenever valid and not
      // stalled; they must form the program-order stream from the last target.
      reset = 1'b1;
      drive(0,0,0,0,0,0);
      reset = 1'b0;
      exp_pc = 32'h0; outstanding = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
      prev_addr = 32'h0; prev_rv_real = 1'b0; resp_addr = 32'h0; delay = 0; consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_rv_real) outstanding = 1'b0;
         if (prev_req && prev_gnt) begin
            outstanding = 1'b1;
            resp_addr   = prev_addr;
            delay       = int'($urandom_range(0, 2));
         end
         if (prev_req && !prev_gnt) begin
            chk("rand.req_held",  {31'h0, req}, 32'h1);
            chk("rand.addr_held", addr,         prev_addr);
         end
         if (outstanding) chk("rand.one_outstanding", {31'h0, req}, 32'h0);
         if (req) chk("rand.addr_aligned", {30'h0, addr[1:0]}, 32'h0);

         rst_stall = ($urandom_range(0, 3) == 0);
         rdr       = ($urandom_range(0, 15) == 0);
         rtgt      = $urandom & 32'h0000_0FFF;
         if (valid && !rst_stall && !rdr) begin
            checks++;
            if (pc !== exp_pc || pc4 !== exp_pc + 32'd4 || instr !== mem(exp_pc)) begin
               failures++;
               $display("FAIL rand.consume pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
                        pc, pc4, instr, exp_pc, exp_pc + 32'd4, mem(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (rdr) exp_pc = rtgt & ~32'h3;

         rv_real = 1'b0;
         if (outstanding && delay == 0) begin
            rvalid = 1'b1; rdata = mem(resp_addr); rv_real = 1'b1;
         end else if (outstanding) begin
            delay--;
            rvalid = 1'b0; rdata = $urandom;
         end else begin
            rvalid = ($urandom_range(0, 7) == 0);
            rdata  = $urandom;
         end
         gnt    = ($urandom_range(0, 2) != 0);
         stall  = rst_stall;
         mux    = rdr ? ALU_RESULT : PC_PLUS4;
         target = rtgt;

         prev_req = req; prev_addr = addr; prev_gnt = gnt; prev_rv_real = rv_real;
         tick();
      end
      chk("rand.progress", {31'h0, (consumed >= 100)}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
